// File: rtl/grant_data_mux.sv
// Captures the arbiter-granted requester word into a two-entry skid buffer and streams it out
// on a valid/ready port tagged with its source. Define GRANT_MUX_ONEHOT_CHECK_EN to reject multi-hot grants.
module grant_data_mux #(
    parameter  int INPUT_WIDTH = 4,
    parameter  int DATA_WIDTH  = 8,
    localparam int SRC_WIDTH   = $clog2(INPUT_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [INPUT_WIDTH-1:0]            Grant,
    input  logic [INPUT_WIDTH*DATA_WIDTH-1:0] Data,
    output logic [INPUT_WIDTH-1:0]            Ack,
    output logic                              Out_Valid,
    input  logic                              Out_Ready,
    output logic [DATA_WIDTH-1:0]             Out_Data,
    output logic [SRC_WIDTH-1:0]              Out_Src,
    output logic                              Grant_Err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e                 state_q;
    logic [DATA_WIDTH-1:0]  head_data_q;
    logic [SRC_WIDTH-1:0]   head_src_q;
    logic [DATA_WIDTH-1:0]  skid_data_q;
    logic [SRC_WIDTH-1:0]   skid_src_q;

    logic [SRC_WIDTH-1:0]   sel_idx;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [INPUT_WIDTH-1:0] sel_onehot;
    logic                   grant_ok;
    logic                   space;
    logic                   accept;
    logic                   pop;

    // Descending scan so the lowest-index set bit wins when the grant is multi-hot.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        sel_idx  = '0;
        sel_data = '0;
        for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
            if (Grant[i]) begin
                sel_idx  = SRC_WIDTH'(i);
                sel_data = Data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_onehot = INPUT_WIDTH'(1) << sel_idx;

`ifdef GRANT_MUX_ONEHOT_CHECK_EN
    logic err_q;
    logic err_d;

    assign grant_ok  = (Grant & (Grant - INPUT_WIDTH'(1))) == '0;
    assign err_d     = err_q | ((|Grant) & ~grant_ok);
    assign Grant_Err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign grant_ok  = 1'b1;
    assign Grant_Err = 1'b0;
`endif

    // Space depends only on registered state so Out_Ready never reaches Ack.
    assign space     = (state_q != TWO);
    assign accept    = !rst && space && (|Grant) && grant_ok;
    assign Ack       = accept ? sel_onehot : '0;
    assign Out_Valid = (state_q != EMPTY);
    assign pop       = Out_Valid && Out_Ready;
    assign Out_Data  = head_data_q;
    assign Out_Src   = head_src_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the skid register is cleared along with the head; both are plain flops, not a RAM array.
            state_q     <= EMPTY;
            head_data_q <= '0;
            head_src_q  <= '0;
            skid_data_q <= '0;
            skid_src_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this block order-independent.
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_data_q <= sel_data;
                        head_src_q  <= sel_idx;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        skid_data_q <= sel_data;
                        skid_src_q  <= sel_idx;
                        state_q     <= TWO;
                    end else if (accept && pop) begin
                        head_data_q <= sel_data;
                        head_src_q  <= sel_idx;
                    end else if (pop) begin
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_data_q <= skid_data_q;
                        head_src_q  <= skid_src_q;
                        state_q     <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule
